sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one single-port SRAM bank (128-bit x 2048, 1-cycle read latency) among NUM_REQ requesters, e.g. the DMA fill engine, the weight fetch unit and the activation writeback unit.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Optional bounded burst lock.
- Read data returns on a shared bus, qualified by a per-requester response strobe.
- Sits between the NPU memory clients and the SRAM macro.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 128, SRAM word width
- DEPTH, 2048, SRAM words
- ADDR_WIDTH, $clog2(DEPTH), address width
- MAX_LOCK, 16, maximum consecutive locked beats before forced release (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester access request
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid&ready
- req_we  in  NUM_REQ  1=write, 0=read
- req_lock  in  NUM_REQ  hold the grant for the next beat (burst)
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_rdata  out  DATA_WIDTH  shared read data
- sram_en  out  1  SRAM enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid 1 cycle after en&!we

Behaviour:
- State registers:
  - ptr: round-robin pointer, reset 0
  - owner: locked requester index, reset 0
  - locked: 1-bit, reset 0
  - lock_cnt: $clog2(MAX_LOCK+1) bits, reset 0
  - rsp_valid: register, reset all-zero
- Reset applies asynchronously on rst_n low; the registers take these values immediately.
- Grant selection (combinational, same cycle):
  - If locked: g=owner; only req_ready[owner] may be 1, and it equals req_valid[owner].
  - Otherwise: g = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ. req_ready is one-hot at g, or all-zero if no valid.
  - At most one req_ready bit is high in any cycle.
- SRAM drive (combinational from the granted requester):
  - sram_en = |(req_valid & req_ready)
  - sram_we, sram_addr and sram_wdata are muxed from g.
  - When idle: sram_we=0; addr/wdata are don't-care but held at requester g's values (no X).
- Read response:
  - A read transfer by i at cycle t gives rsp_valid[i]=1 at t+1, with rsp_rdata = sram_rdata.
  - Writes produce no response.
  - rsp_valid is one-hot or zero; back-to-back reads give back-to-back responses.
- Pointer update, on a transfer by g with locked=0 and req_lock[g]=0: ptr <= (g+1) mod NUM_REQ.
- Lock entry: transfer by g with req_lock[g]=1 and locked=0 sets locked=1, owner=g, lock_cnt=1.
- Lock continuation: transfer by owner with req_lock=1 increments lock_cnt.
- Lock release, on either of the following: ptr <= (owner+1) mod NUM_REQ, locked=0, lock_cnt=0.
  - A transfer by owner with req_lock=0.
  - A locked transfer that makes lock_cnt reach MAX_LOCK (forced release; that beat still completes).
- Owner drops valid while locked: no transfer, the lock is held, others remain stalled. MAX_LOCK counts transfers, not cycles, so clients must not idle while locked.
- Write-then-read to the same address on consecutive cycles returns the new data (SRAM ordering).
- Requester inputs must stay stable while valid&!ready; the arbiter never revokes ready within a cycle.
- Reset mid-operation: a pending rsp_valid is cleared; no response is emitted after reset release for pre-reset reads.

Decomposition:
- Package npu_mem_pkg:
  - SRAM_DATA_WIDTH=128, SRAM_DEPTH=2048, SRAM_ADDR_WIDTH
  - requester index constants: REQ_DMA=0, REQ_WFETCH=1, REQ_WB=2
- One sub-module, rr_pick: combinational, inputs valid vector and ptr; outputs one-hot grant and index.
- All state (ptr, lock, rsp_valid) lives in sram_arbiter.

Test Plan:
- All three requesters hold valid reads to addrs 0x10/0x20/0x30 for 6 cycles -> grants rotate 0,1,2,0,1,2. rsp_valid follows one cycle later with the matching data.
- Requester 1 writes 0xDEAD_BEEF to 0x7FF, then reads it on the next cycle -> rsp_valid[1] at read+1 with rsp_rdata=0xDEAD_BEEF; sram_we high only on the write cycle.
- Requester 0 bursts 4 locked writes (req_lock=1,1,1,0) while 1 and 2 request -> req_ready[0] for 4 consecutive beats, then grant goes to 1, then 2.
- MAX_LOCK=16; requester 2 holds req_lock=1 for 20 beats with others valid -> forced release after beat 16, and requester 0 is granted at the next cycle.
- Read by requester 2 issued, rst_n pulsed low mid-cycle before the response -> rsp_valid all-zero immediately, ptr=0, req_ready follows the priority from 0 after release.
- Only requester 1 valid, single read to 0x000 -> ready same cycle, sram_en=1 for exactly 1 cycle, ptr becomes 2.

Source files
------------

// File: rtl/npu_mem_pkg.sv
// Shared constants for the NPU SRAM bank and its memory clients.
package npu_mem_pkg;

  localparam int SRAM_DATA_WIDTH = 128;
  localparam int SRAM_DEPTH      = 2048;
  localparam int SRAM_ADDR_WIDTH = $clog2(SRAM_DEPTH);

  localparam int REQ_DMA    = 0;
  localparam int REQ_WFETCH = 1;
  localparam int REQ_WB     = 2;

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant    = '0;
    idx      = ptr;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && valid[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ clients, with bounded burst lock.
module sram_arbiter
  import npu_mem_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int DEPTH      = SRAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_LOCK   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          sram_en,
  output logic                          sram_we,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_wdata,
  input  logic [DATA_WIDTH-1:0]         sram_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic               locked;
  logic [CNT_W-1:0]   lock_cnt;
  logic [CNT_W-1:0]   lock_cnt_nxt;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   g;
  logic               xfer;
  logic               g_lock;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    else return i + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // A held lock overrides the rotation: only the owner can see ready.
  always_comb begin
    g         = pick_idx;
    req_ready = pick_grant;
    if (locked) begin
      g                = owner;
      req_ready        = '0;
      req_ready[owner] = req_valid[owner];
    end
  end

  assign xfer         = |(req_valid & req_ready);
  assign g_lock       = req_lock[g];
  assign lock_cnt_nxt = lock_cnt + 1'b1;

  always_comb begin
    sram_addr  = req_addr[ADDR_WIDTH-1:0];
    sram_wdata = req_wdata[DATA_WIDTH-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == g) begin
        sram_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sram_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sram_en   = xfer;
  assign sram_we   = xfer & req_we[g];
  assign rsp_rdata = sram_rdata;

  // Stage boundary: grant/lock state and the read-response strobe, aligned with SRAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      owner     <= '0;
      locked    <= 1'b0;
      lock_cnt  <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= req_valid & req_ready & ~req_we;
      if (xfer) begin
        if (!locked) begin
          if (g_lock && (MAX_LOCK > 1)) begin
            locked   <= 1'b1;
            owner    <= g;
            lock_cnt <= CNT_W'(1);
          end else begin
            ptr <= wrap_inc(g);
          end
        end else if (g_lock && (lock_cnt_nxt != CNT_W'(MAX_LOCK))) begin
          lock_cnt <= lock_cnt_nxt;
        end else begin
          ptr      <= wrap_inc(owner);
          locked   <= 1'b0;
          lock_cnt <= '0;
        end
      end
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table plus hand sequences for lock limit and async reset.
module tb_sram_arbiter;
  import npu_mem_pkg::*;

  localparam int N  = 3;
  localparam int DW = 128;
  localparam int AW = 11;
  localparam int ML = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            sram_en;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [DW-1:0]   sram_rdata = '0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .DEPTH      (2048),
    .ADDR_WIDTH (AW),
    .MAX_LOCK   (ML)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural single-port SRAM, one-cycle read latency.
  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  we;
    logic [2:0]  lock;
    logic [10:0] a0;
    logic [10:0] a1;
    logic [10:0] a2;
    logic [31:0] wd;
    logic [2:0]  exp_ready;
    logic        exp_en;
    logic        exp_we;
    logic [2:0]  exp_rsp;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] w, input logic [2:0] l,
                              input logic [10:0] a0, input logic [10:0] a1, input logic [10:0] a2,
                              input logic [31:0] wd, input logic [2:0] er, input logic ee,
                              input logic ew, input logic [2:0] ers, input logic crd,
                              input logic [31:0] erd);
    vec_t x;
    x.valid = v;  x.we = w;  x.lock = l;
    x.a0 = a0;  x.a1 = a1;  x.a2 = a2;  x.wd = wd;
    x.exp_ready = er;  x.exp_en = ee;  x.exp_we = ew;
    x.exp_rsp = ers;  x.chk_rd = crd;  x.exp_rd = erd;
    return x;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [2:0] w, input logic [2:0] l,
                       input logic [10:0] a0, input logic [10:0] a1, input logic [10:0] a2,
                       input logic [31:0] wd);
    req_valid = v;
    req_we    = w;
    req_lock  = l;
    req_addr  = {a2, a1, a0};
    req_wdata = {3{{96'h0, wd}}};
  endtask

  task automatic run_vec(input vec_t x, input string tag);
    logic [10:0] ea;
    @(posedge clk);
    #1;
    drive(x.valid, x.we, x.lock, x.a0, x.a1, x.a2, x.wd);
    @(negedge clk);
    chk({tag, " ready"}, 128'(req_ready), 128'(x.exp_ready));
    chk({tag, " en"},    128'(sram_en),   128'(x.exp_en));
    chk({tag, " we"},    128'(sram_we),   128'(x.exp_we));
    chk({tag, " rsp"},   128'(rsp_valid), 128'(x.exp_rsp));
    if (x.chk_rd) chk({tag, " rdata"}, rsp_rdata, {96'h0, x.exp_rd});
    if (x.exp_en) begin
      ea = x.exp_ready[0] ? x.a0 : (x.exp_ready[1] ? x.a1 : x.a2);
      chk({tag, " addr"}, 128'(sram_addr), 128'(ea));
      if (x.exp_we) chk({tag, " wdata"}, sram_wdata, {96'h0, x.wd});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] wb_bit;
    logic [2:0] er;
    wb_bit = 3'(1 << REQ_WB);

    // preload, round-robin reads, write-then-read, single read
    vecs.push_back(mk(3'b111, 3'b111, 3'b000, 11'h10, 11'h20, 11'h30, 32'h1111, 3'b001, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b110, 3'b110, 3'b000, 11'h10, 11'h20, 11'h30, 32'h2222, 3'b010, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b100, 3'b100, 3'b000, 11'h10, 11'h20, 11'h30, 32'h3333, 3'b100, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b001, 1, 0, 3'b000, 0, 0));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b010, 1, 0, 3'b001, 1, 32'h1111));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b100, 1, 0, 3'b010, 1, 32'h2222));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b001, 1, 0, 3'b100, 1, 32'h3333));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b010, 1, 0, 3'b001, 1, 32'h1111));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b100, 1, 0, 3'b010, 1, 32'h2222));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b000, 0, 0, 3'b100, 1, 32'h3333));
    vecs.push_back(mk(3'b010, 3'b010, 3'b000, 11'h0, 11'h7FF, 11'h0, 32'hDEADBEEF, 3'b010, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b010, 3'b000, 3'b000, 11'h0, 11'h7FF, 11'h0, 0, 3'b010, 1, 0, 3'b000, 0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 11'h0, 11'h7FF, 11'h0, 0, 3'b000, 0, 0, 3'b010, 1, 32'hDEADBEEF));
    vecs.push_back(mk(3'b010, 3'b000, 3'b000, 11'h0, 11'h000, 11'h0, 0, 3'b010, 1, 0, 3'b000, 0, 0));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b100, 1, 0, 3'b010, 0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b000, 0, 0, 3'b100, 1, 32'h3333));
    // 4-beat locked write burst by requester 0, with an owner gap mid-burst
    vecs.push_back(mk(3'b111, 3'b001, 3'b001, 11'h40, 11'h20, 11'h30, 32'hA0, 3'b001, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b111, 3'b001, 3'b001, 11'h41, 11'h20, 11'h30, 32'hA1, 3'b001, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b110, 3'b000, 3'b001, 11'h42, 11'h20, 11'h30, 0, 3'b000, 0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(3'b111, 3'b001, 3'b001, 11'h42, 11'h20, 11'h30, 32'hA2, 3'b001, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b111, 3'b001, 3'b000, 11'h43, 11'h20, 11'h30, 32'hA3, 3'b001, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b110, 3'b000, 3'b000, 11'h43, 11'h20, 11'h30, 0, 3'b010, 1, 0, 3'b000, 0, 0));
    vecs.push_back(mk(3'b100, 3'b000, 3'b000, 11'h43, 11'h20, 11'h30, 0, 3'b100, 1, 0, 3'b010, 1, 32'h2222));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 11'h43, 11'h20, 11'h30, 0, 3'b000, 0, 0, 3'b100, 1, 32'h3333));

    // reset state
    drive(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0);
    #12;
    chk("reset rsp", 128'(rsp_valid), 128'(3'b000));
    chk("reset ready all", 128'(req_ready), 128'(3'b001));
    drive(3'b110, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0);
    #1;
    chk("reset ready 1,2", 128'(req_ready), 128'(3'b010));
    drive(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // forced release after MAX_LOCK locked beats by requester 2
    for (int b = 1; b <= 18; b++) begin
      @(posedge clk);
      #1;
      drive((b == 1) ? wb_bit : 3'b111, 3'b111, wb_bit, 11'h100, 11'h101, 11'h102, 32'(b));
      @(negedge clk);
      er = (b <= ML) ? wb_bit : ((b == ML + 1) ? 3'b001 : 3'b010);
      chk($sformatf("lock b%0d ready", b), 128'(req_ready), 128'(er));
      chk($sformatf("lock b%0d en", b), 128'(sram_en), 128'(1'b1));
    end

    // async reset with a read response pending
    @(posedge clk);
    #1;
    drive(3'b100, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0);
    @(negedge clk);
    chk("pre-rst ready", 128'(req_ready), 128'(3'b100));
    @(posedge clk);
    #1;
    chk("pre-rst rsp", 128'(rsp_valid), 128'(3'b100));
    chk("pre-rst rdata", rsp_rdata, {96'h0, 32'h3333});
    drive(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid-rst rsp", 128'(rsp_valid), 128'(3'b000));
    drive(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0);
    #1;
    chk("mid-rst ready", 128'(req_ready), 128'(3'b001));
    drive(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b001, 1, 0, 3'b000, 0, 0), "post-rst0");
    run_vec(mk(3'b111, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b010, 1, 0, 3'b001, 1, 32'h1111), "post-rst1");
    run_vec(mk(3'b000, 3'b000, 3'b000, 11'h10, 11'h20, 11'h30, 0, 3'b000, 0, 0, 3'b010, 1, 32'h2222), "post-rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
